dcp_pkt_fifo: RTL and testbench
===============================

Name: dcp_pkt_fifo

Overview:
Packet-aware store-and-forward successor of the decoupled FIFO, for switch ingress and egress queues. Beats carry a Last flag and, on the last beat, an Err flag. A packet becomes visible at the output only once its Last beat is written. Errored packets and packets longer than the FIFO are discarded by rewinding the write pointer. The output is registered, with full-throughput valid/ready on both sides.

Parameters:
DATA_WIDTH, 64, payload width in bits.
DEPTH, 64, storage beats; power of two, at least 4.
AFULL_THRESH, 8, oAlmostFull asserts when free entries < AFULL_THRESH.
PCNT_W, 8, width of the committed-packet counter; must satisfy 2**PCNT_W > DEPTH.

Ports:
iClk  in  1  clock
iRst  in  1  synchronous reset, active-high
iFlush  in  1  synchronous flush
iInVld  in  1  input beat valid
oInRdy  out  1  input ready
iInPld  in  DATA_WIDTH  input payload
iInLast  in  1  last beat of packet
iInErr  in  1  packet error; sampled only with iInLast=1
oOutVld  out  1  output beat valid
iOutRdy  in  1  output ready
oOutPld  out  DATA_WIDTH  output payload
oOutLast  out  1  output last beat
oUsage  out  $clog2(DEPTH)+1  occupied entries (memory plus output register)
oAlmostFull  out  1  free entries < AFULL_THRESH
oDropPulse  out  1  one-cycle pulse per discarded packet

Behaviour:
- Reset and flush: iRst=1 at an edge clears all state. After that edge every output is 0, including oInRdy, oOutVld, oUsage, oDropPulse. oInRdy rises the cycle after iRst deasserts.
- Storage: memory of DEPTH x (DATA_WIDTH+1); the extra bit stores Last. Pointers are $clog2(DEPTH)+1 bits with a wrap bit: rd_ptr, wr_ptr (tentative), cm_ptr (commit).
  - full: wr_ptr - rd_ptr == DEPTH.
  - free entries: DEPTH - (wr_ptr - rd_ptr).
- Write FSM has three states: IDLE, WRITE, DROP.
  - IDLE/WRITE: oInRdy = !full. A handshake writes to mem[wr_ptr] and increments wr_ptr.
  - Non-last beat: state goes to WRITE.
  - Last beat, Err=0: cm_ptr <= wr_ptr+1, packet count +1, state goes to IDLE.
  - Last beat, Err=1: wr_ptr <= cm_ptr, oDropPulse=1 next cycle, state goes to IDLE.
  - Oversize: in WRITE with full && cm_ptr==rd_ptr && no committed beats, wr_ptr <= cm_ptr and state goes to DROP.
  - DROP: oInRdy=1 and beats are discarded. At the Last handshake: oDropPulse, state goes to IDLE.
- Read side:
  - pkt_cnt counts committed packets not fully fetched into the output register.
  - Fetch when pkt_cnt>0 and (output register empty or output handshake this cycle). Fetch loads mem[rd_ptr] and increments rd_ptr.
  - Fetching a Last beat decrements pkt_cnt. A simultaneous commit and last-fetch leaves pkt_cnt unchanged.
- Latency: last-beat handshake in cycle T gives commit at end of T, fetch in T+1, oOutVld=1 in T+2. With iOutRdy held high, beats stream one per cycle, including back-to-back packets.
- Output stability: while oOutVld=1 and iOutRdy=0, oOutPld and oOutLast are held stable.
- oUsage = (wr_ptr - rd_ptr) + output-register valid. Uncommitted beats are counted. oAlmostFull is combinational from the pointers.
- iFlush: same effect as iRst on pointers, pkt_cnt and the output register. If iFlush occurs mid-packet (state WRITE, or an input handshake with iInLast=0 in the flush cycle), the next state is DROP so the packet tail is discarded. Flush does not pulse oDropPulse.
- Input handshake during the iFlush cycle: the beat is ignored.

Optional Feature:
DCP_PKT_FIFO_STATS_EN.
- Defined: adds ports oPktCnt (32, out) and oDropCnt (32, out). They are saturating counters of committed and dropped packets, cleared by iRst only, not by iFlush.
- Undefined: the ports are absent and no counter logic is built.

Decomposition:
- Package dcp_pkt_fifo_pkg holds:
  - typedef wr_state_e {IDLE, WRITE, DROP}
  - typedef mem_word_t (a struct of {last, pld}, parameterised via DATA_WIDTH in the module)
  - constant STATS_W = 32.
- One sub-module, dcp_pkt_fifo_mem: a simple dual-port register array (write port, registered read port), replaceable by a macro RAM.

Test Plan:
- Reset: hold iRst 3 cycles, push during reset -> oInRdy=0, oOutVld=0, oUsage=0; oInRdy=1 one cycle after release.
- Single 4-beat packet, Err=0, Last at T, iOutRdy=1 -> oOutVld first at T+2; 4 consecutive beats; oOutLast on the 4th; oUsage peaks at 4, returns to 0.
- Errored packet: 3-beat packet with Err=1 followed by a good 2-beat packet -> only the 2 good beats emerge; oDropPulse=1 exactly once; oUsage 0 after the drop.
- Oversize, DEPTH=8: 12-beat packet -> after 8 beats the FSM enters DROP, oInRdy stays 1, nothing is output, one oDropPulse; a following 2-beat packet passes intact.
- Backpressure: two committed 3-beat packets with iOutRdy toggled 1,0,0,1 -> payload held stable while stalled, order preserved, no beat duplicated or lost.
- Flush mid-packet: 2 beats written, iFlush for 1 cycle, remaining 2 beats with Last -> beats discarded, oUsage=0, no output, no oDropPulse; the next packet delivered normally.

Source files
------------

// File: rtl/dcp_pkt_fifo_pkg.sv
// Shared types and constants for the packet-aware store-and-forward FIFO.
// The beat word (last + payload) is declared in the top, where DATA_WIDTH is known.
package dcp_pkt_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

    localparam int STATS_W = 32;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dcp_pkt_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read.
// The read register doubles as the FIFO output register, so it clears with reset/flush.
module dcp_pkt_fifo_mem #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dcp_pkt_fifo.sv
// Packet-aware store-and-forward FIFO: packets become readable only once their last beat
// is written; errored/oversize packets are rewound away. Optional counters: DCP_PKT_FIFO_STATS_EN.
module dcp_pkt_fifo
    import dcp_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 64,
    parameter int AFULL_THRESH = 8,
    parameter int PCNT_W       = 8
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iFlush,
    input  logic                      iInVld,
    output logic                      oInRdy,
    input  logic [DATA_WIDTH-1:0]     iInPld,
    input  logic                      iInLast,
    input  logic                      iInErr,
    output logic                      oOutVld,
    input  logic                      iOutRdy,
    output logic [DATA_WIDTH-1:0]     oOutPld,
    output logic                      oOutLast,
    output logic [$clog2(DEPTH):0]    oUsage,
    output logic                      oAlmostFull,
    output logic                      oDropPulse
`ifdef DCP_PKT_FIFO_STATS_EN
    ,
    output logic [STATS_W-1:0]        oPktCnt,
    output logic [STATS_W-1:0]        oDropCnt
`endif
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] pld;
    } mem_word_t;

    wr_state_e         r_state, w_next_state;
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_cm_ptr;
    logic [PCNT_W-1:0] r_pkt_cnt;
    logic              r_out_vld, r_drop_pulse, r_rdy_en, r_quiet_drop;
    logic              r_last_bits [DEPTH];

    logic [PW-1:0] w_used;
    logic          w_full, w_in_hs_raw, w_in_hs, w_accept, w_commit;
    logic          w_err_drop, w_tail_drop, w_oversize, w_fetch, w_fetch_last;
    mem_word_t     w_wr_word, w_rd_word;

    assign w_used       = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_used == DEPTH_P);
    assign w_in_hs_raw  = iInVld & oInRdy;
    assign w_in_hs      = w_in_hs_raw & ~iFlush;
    assign w_accept     = w_in_hs & (r_state != DROP);
    assign w_commit     = w_accept & iInLast & ~iInErr;
    assign w_err_drop   = w_accept & iInLast & iInErr;
    // A tail eaten because of a flush is not a discarded packet worth reporting.
    assign w_tail_drop  = w_in_hs & (r_state == DROP) & iInLast & ~r_quiet_drop;
    assign w_oversize   = (r_state == WRITE) & w_full & (r_cm_ptr == r_rd_ptr);
    assign w_fetch      = (r_pkt_cnt != '0) & (~r_out_vld | iOutRdy);
    assign w_fetch_last = w_fetch & r_last_bits[r_rd_ptr[AW-1:0]];

    // Write FSM: state register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write FSM: next state
    always_comb begin
        w_next_state = r_state;
        if (iFlush) begin
            w_next_state = ((r_state != IDLE) || (w_in_hs_raw && !iInLast)) ? DROP : IDLE;
        end else begin
            case (r_state)
                IDLE, WRITE: begin
                    if (w_accept) begin
                        w_next_state = iInLast ? IDLE : WRITE;
                    end else if (w_oversize) begin
                        w_next_state = DROP;
                    end
                end
                DROP: begin
                    if (w_in_hs && iInLast) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Write FSM: outputs
    always_comb begin
        oInRdy = r_rdy_en & ((r_state == DROP) | ~w_full);
    end

    always_ff @(posedge iClk) begin
        if (iRst || iFlush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cm_ptr  <= '0;
            r_pkt_cnt <= '0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_err_drop || w_oversize) begin
                r_wr_ptr <= r_cm_ptr;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_commit) begin
                r_cm_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_commit && !w_fetch_last) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else if (!w_commit && w_fetch_last) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end
            if (w_fetch) begin
                r_out_vld <= 1'b1;
            end else if (iOutRdy) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_drop_pulse <= 1'b0;
            r_rdy_en     <= 1'b0;
            r_quiet_drop <= 1'b0;
        end else begin
            r_drop_pulse <= w_err_drop | w_tail_drop;
            r_rdy_en     <= 1'b1;
            if (iFlush) begin
                r_quiet_drop <= 1'b1;
            end else if (w_oversize) begin
                r_quiet_drop <= 1'b0;
            end
        end
    end

    // Shadow of the Last bits so the fetch logic knows a packet boundary before the read completes.
    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_last_bits[r_wr_ptr[AW-1:0]] <= iInLast;
        end
    end

    assign w_wr_word = '{last: iInLast, pld: iInPld};

    dcp_pkt_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (iClk),
        .i_clr     (iRst | iFlush),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_fetch),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_word)
    );

    assign oOutVld     = r_out_vld;
    assign oOutPld     = w_rd_word.pld;
    assign oOutLast    = w_rd_word.last;
    assign oUsage      = w_used + PW'(r_out_vld);
    assign oAlmostFull = (DEPTH_P - w_used) < AFULL_P;
    assign oDropPulse  = r_drop_pulse;

`ifdef DCP_PKT_FIFO_STATS_EN
    logic [STATS_W-1:0] r_pkt_total, r_drop_total;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_pkt_total  <= '0;
            r_drop_total <= '0;
        end else begin
            if (w_commit) begin
                r_pkt_total <= sat_inc(r_pkt_total);
            end
            if (w_err_drop || w_tail_drop) begin
                r_drop_total <= sat_inc(r_drop_total);
            end
        end
    end

    assign oPktCnt  = r_pkt_total;
    assign oDropCnt = r_drop_total;
`endif

endmodule

// File: tb/tb_dcp_pkt_fifo.sv
// Directed bench for dcp_pkt_fifo (DEPTH=8): packet-level delivery model with an expected
// beat queue, an every-cycle output monitor, and literal checks on latency, usage and drops.
module tb_dcp_pkt_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AFT   = 4;
    localparam int PCW   = 4;
    localparam int UW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          iRst, iFlush, iInVld, iInLast, iInErr, iOutRdy;
    logic [DW-1:0] iInPld;
    logic          oInRdy, oOutVld, oOutLast, oAlmostFull, oDropPulse;
    logic [DW-1:0] oOutPld;
    logic [UW-1:0] oUsage;
`ifdef DCP_PKT_FIFO_STATS_EN
    logic [31:0]   pkt_cnt_o, drop_cnt_o;
`endif

    dcp_pkt_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFT),
        .PCNT_W       (PCW)
    ) dut (
        .iClk        (clk),
        .iRst        (iRst),
        .iFlush      (iFlush),
        .iInVld      (iInVld),
        .oInRdy      (oInRdy),
        .iInPld      (iInPld),
        .iInLast     (iInLast),
        .iInErr      (iInErr),
        .oOutVld     (oOutVld),
        .iOutRdy     (iOutRdy),
        .oOutPld     (oOutPld),
        .oOutLast    (oOutLast),
        .oUsage      (oUsage),
        .oAlmostFull (oAlmostFull),
        .oDropPulse  (oDropPulse)
`ifdef DCP_PKT_FIFO_STATS_EN
        ,
        .oPktCnt     (pkt_cnt_o),
        .oDropCnt    (drop_cnt_o)
`endif
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];
    int exp_drops = 0;
    int drop_seen = 0;
    int usage_peak = 0;
    int first_vld_cyc = -1;
    int last_out_cyc = -1;
    bit prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard / monitor: every output handshake must match the head of exp_q.
    always @(negedge clk) begin
        logic [DW:0] w;
        if (!iRst) begin
            if (oDropPulse) drop_seen++;
        end
        if (iRst || iFlush) begin
            prev_stall = 1'b0;
        end else begin
            if (int'(oUsage) > usage_peak) usage_peak = int'(oUsage);
            if (prev_stall) begin
                check("hold_vld", 32'(oOutVld), 32'd1);
                check("hold_word", 32'({oOutLast, oOutPld}), 32'(prev_word));
            end
            if (oOutVld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (oOutVld && iOutRdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected no beat", {oOutLast, oOutPld});
                end else begin
                    w = exp_q.pop_front();
                    check("out_word", 32'({oOutLast, oOutPld}), 32'(w));
                end
                if (oOutLast) last_out_cyc = cyc;
            end
            prev_stall = oOutVld && !iOutRdy;
            prev_word  = {oOutLast, oOutPld};
        end
    end

    // Driver tasks
    task automatic send_beat(input logic [DW-1:0] pld, input logic last, input logic err,
                             output int stalls);
        int n = 0;
        iInVld  = 1'b1;
        iInPld  = pld;
        iInLast = last;
        iInErr  = err;
        @(negedge clk);
        while (!oInRdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_timeout: got oInRdy=0 for %0d cycles expected 1", n);
        end
        stalls = n;
        @(posedge clk);
        #1;
        iInVld  = 1'b0;
        iInLast = 1'b0;
        iInErr  = 1'b0;
    endtask

    // Model: a packet emerges iff it is error-free and fits in an empty FIFO.
    task automatic send_pkt(input int id, input int len, input bit err,
                            output int late_stalls, output int t_last);
        bit delivered;
        int st;
        logic [7:0] idb, bb;
        logic [DW-1:0] pld;
        logic last;
        delivered   = !err && (len <= DEPTH);
        late_stalls = 0;
        if (!delivered) exp_drops++;
        for (int b = 0; b < len; b++) begin
            idb  = id[7:0];
            bb   = b[7:0];
            pld  = {idb, bb};
            last = (b == len - 1);
            if (delivered) exp_q.push_back({last, pld});
            send_beat(pld, last, err && last, st);
            if (b > DEPTH) late_stalls += st;
        end
        t_last = cyc;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t_last, late, d0, n;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset with a push attempt held during reset
        iRst = 1'b1; iFlush = 1'b0; iInVld = 1'b1; iInPld = 16'hdead;
        iInLast = 1'b1; iInErr = 1'b0; iOutRdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inrdy", 32'(oInRdy), 32'd0);
        check("rst_outvld", 32'(oOutVld), 32'd0);
        check("rst_usage", 32'(oUsage), 32'd0);
        check("rst_drop", 32'(oDropPulse), 32'd0);
        check("rst_afull", 32'(oAlmostFull), 32'd0);
        check("rst_pld", 32'(oOutPld), 32'd0);
        @(posedge clk);
        #1;
        iRst = 1'b0;
        iInVld = 1'b0;
        @(negedge clk);
        check("inrdy_release_cycle", 32'(oInRdy), 32'd0);
        @(negedge clk);
        check("inrdy_after_release", 32'(oInRdy), 32'd1);
        check("usage_after_release", 32'(oUsage), 32'd0);
        @(posedge clk);
        #1;

        // Single 4-beat packet
        usage_peak = 0; first_vld_cyc = -1;
        send_pkt(1, 4, 1'b0, late, t_last);
        wait_drain("pkt1_drained");
        check("latency", 32'(first_vld_cyc), 32'(t_last + 1));
        check("stream", 32'(last_out_cyc), 32'(first_vld_cyc + 3));
        check("usage_peak", 32'(usage_peak), 32'd4);
        check("usage_empty1", 32'(oUsage), 32'd0);

        // Errored packet then a good one
        d0 = drop_seen;
        @(posedge clk); #1;
        send_pkt(2, 3, 1'b1, late, t_last);
        send_pkt(3, 2, 1'b0, late, t_last);
        wait_drain("err_drained");
        check("err_drop_once", 32'(drop_seen - d0), 32'd1);
        check("usage_empty2", 32'(oUsage), 32'd0);

        // Oversize packet, then a normal one
        d0 = drop_seen;
        @(posedge clk); #1;
        send_pkt(4, 12, 1'b0, late, t_last);
        check("drop_no_stall", 32'(late), 32'd0);
        repeat (3) @(negedge clk);
        check("oversize_drop_once", 32'(drop_seen - d0), 32'd1);
        check("usage_empty3", 32'(oUsage), 32'd0);
        @(posedge clk); #1;
        send_pkt(5, 2, 1'b0, late, t_last);
        wait_drain("after_oversize_drained");

        // Backpressure with two committed packets
        d0 = drop_seen;
        @(posedge clk); #1;
        iOutRdy = 1'b0;
        send_pkt(6, 3, 1'b0, late, t_last);
        send_pkt(7, 3, 1'b0, late, t_last);
        @(negedge clk);
        check("bp_usage", 32'(oUsage), 32'd6);
        check("bp_afull", 32'(oAlmostFull), 32'd1);
        @(posedge clk); #1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            iOutRdy = pat[n % 4];
            @(posedge clk);
            #1;
            n++;
        end
        iOutRdy = 1'b1;
        wait_drain("bp_drained");
        check("bp_no_drop", 32'(drop_seen - d0), 32'd0);
        check("bp_afull_clear", 32'(oAlmostFull), 32'd0);

        // Flush mid-packet
        d0 = drop_seen;
        @(posedge clk); #1;
        send_beat(16'h0800, 1'b0, 1'b0, late);
        send_beat(16'h0801, 1'b0, 1'b0, late);
        iFlush = 1'b1;
        @(posedge clk); #1;
        iFlush = 1'b0;
        @(negedge clk);
        check("flush_usage", 32'(oUsage), 32'd0);
        check("flush_outvld", 32'(oOutVld), 32'd0);
        @(posedge clk); #1;
        send_beat(16'h0802, 1'b0, 1'b0, late);
        send_beat(16'h0803, 1'b1, 1'b0, late);
        repeat (4) @(negedge clk);
        check("flush_tail_usage", 32'(oUsage), 32'd0);
        check("flush_no_drop", 32'(drop_seen - d0), 32'd0);
        @(posedge clk); #1;
        send_pkt(9, 3, 1'b0, late, t_last);
        wait_drain("after_flush_drained");

        check("drop_total", 32'(drop_seen), 32'(exp_drops));
        check("drop_total_literal", 32'(drop_seen), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
